// File: rtl/mem_rd_data_align.sv
// mem_rd_data_align: load-side data path between Execute and the data-memory
// read port. Accepts one load, issues one or two word-aligned reads (two when
// the access crosses a word boundary), then extracts, merges and sign/zero
// extends the returned bytes into a writeback value held until accepted.
module mem_rd_data_align #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [1:0]            ld_size,
   input  logic                  ld_signed,
   input  logic [TAG_WIDTH-1:0]  ld_rd,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rsp_data,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic [TAG_WIDTH-1:0]  wb_rd,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ0,
      S_WAIT0,
      S_REQ1,
      S_WAIT1,
      S_DONE
   } state_e;

   state_e                  state_q;
   logic                    ld_ready_q;
   logic                    busy_q;
   logic                    mem_req_valid_q;
   logic [ADDR_WIDTH-1:0]   mem_req_addr_q;
   logic                    wb_valid_q;
   logic [DATA_WIDTH-1:0]   wb_data_q;
   logic [TAG_WIDTH-1:0]    wb_rd_q;

   // Captured load attributes and the first returned word (pure data, no reset).
   logic [1:0]              off_q;
   logic [1:0]              size_q;
   logic                    signed_q;
   logic [TAG_WIDTH-1:0]    rd_q;
   logic                    split_q;
   logic [DATA_WIDTH-1:0]   word0_q;

   logic                    split_d;
   logic [DATA_WIDTH-1:0]   wb_data_d;

   // A half crosses a word only at offset 3; a word crosses at any nonzero offset.
   function automatic logic is_split(input logic [1:0] off, input logic [1:0] size);
      case (size)
         2'b00:   is_split = 1'b0;
         2'b01:   is_split = (off == 2'b11);
         default: is_split = (off != 2'b00);
      endcase
   endfunction

   // Shift the {word1,word0} pair down to the addressed byte, then extend.
   function automatic logic [DATA_WIDTH-1:0] extract(input logic [2*DATA_WIDTH-1:0] pair,
                                                     input logic [1:0] off,
                                                     input logic [1:0] size,
                                                     input logic       sgn);
      logic [DATA_WIDTH-1:0] win;
      win = DATA_WIDTH'(pair >> {off, 3'b000});
      case (size)
         2'b00:   extract = {{(DATA_WIDTH-8){sgn & win[7]}}, win[7:0]};
         2'b01:   extract = {{(DATA_WIDTH-16){sgn & win[15]}}, win[15:0]};
         default: extract = win;
      endcase
   endfunction

   // Split decision for the incoming load and the writeback value formed from
   // the response arriving this cycle (word1 is zero for a single-word load).
   always_comb begin
      split_d = is_split(ld_addr[1:0], ld_size);
      if (state_q == S_WAIT1) begin
         wb_data_d = extract({mem_rsp_data, word0_q}, off_q, size_q, signed_q);
      end else begin
         wb_data_d = extract({{DATA_WIDTH{1'b0}}, mem_rsp_data}, off_q, size_q, signed_q);
      end
   end

   // Load sequencer: all outputs are registered and change only on state entry/exit.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= S_IDLE;
         ld_ready_q      <= 1'b0;
         busy_q          <= 1'b0;
         mem_req_valid_q <= 1'b0;
         mem_req_addr_q  <= '0;
         wb_valid_q      <= 1'b0;
         wb_data_q       <= '0;
         wb_rd_q         <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               ld_ready_q <= 1'b1;
               if (ld_valid && ld_ready_q) begin
                  off_q           <= ld_addr[1:0];
                  size_q          <= ld_size;
                  signed_q        <= ld_signed;
                  rd_q            <= ld_rd;
                  split_q         <= split_d;
                  mem_req_valid_q <= 1'b1;
                  mem_req_addr_q  <= {ld_addr[ADDR_WIDTH-1:2], 2'b00};
                  ld_ready_q      <= 1'b0;
                  busy_q          <= 1'b1;
                  state_q         <= S_REQ0;
               end
            end
            S_REQ0: begin
               if (mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= S_WAIT0;
               end
            end
            S_WAIT0: begin
               if (mem_rsp_valid) begin
                  word0_q <= mem_rsp_data;
                  if (split_q) begin
                     // Second word follows the first; address wraps at the top of memory.
                     mem_req_valid_q <= 1'b1;
                     mem_req_addr_q  <= mem_req_addr_q + ADDR_WIDTH'(4);
                     state_q         <= S_REQ1;
                  end else begin
                     wb_valid_q <= 1'b1;
                     wb_data_q  <= wb_data_d;
                     wb_rd_q    <= rd_q;
                     state_q    <= S_DONE;
                  end
               end
            end
            S_REQ1: begin
               if (mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= S_WAIT1;
               end
            end
            S_WAIT1: begin
               if (mem_rsp_valid) begin
                  wb_valid_q <= 1'b1;
                  wb_data_q  <= wb_data_d;
                  wb_rd_q    <= rd_q;
                  state_q    <= S_DONE;
               end
            end
            S_DONE: begin
               if (wb_ready) begin
                  wb_valid_q <= 1'b0;
                  busy_q     <= 1'b0;
                  ld_ready_q <= 1'b1;
                  state_q    <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ld_ready      = ld_ready_q;
   assign busy          = busy_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_req_addr  = mem_req_addr_q;
   assign wb_valid      = wb_valid_q;
   assign wb_data       = wb_data_q;
   assign wb_rd         = wb_rd_q;

endmodule

// File: tb/tb_mem_rd_data_align.sv
// tb_mem_rd_data_align: directed vectors for the load alignment block with a
// small word-addressed memory responder (one-cycle response latency).
module tb_mem_rd_data_align;

   logic        clock;
   logic        reset;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_addr;
   logic [1:0]  ld_size;
   logic        ld_signed;
   logic [4:0]  ld_rd;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        busy;

   int n_vec = 0;
   int n_bad = 0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] req_log [$];
   logic        pending;
   logic [31:0] pend_addr;
   logic        auto_rsp;
   logic        inj;

   typedef struct {
      logic [31:0] a;
      logic [1:0]  sz;
      logic        sg;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          nreq;
      logic [31:0] r0;
      logic [31:0] r1;
      logic [31:0] w0;
      logic [31:0] w1;
      int          lat;
   } vec_t;

   vec_t vt [10];

   mem_rd_data_align #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .TAG_WIDTH (5)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_addr      (ld_addr),
      .ld_size      (ld_size),
      .ld_signed    (ld_signed),
      .ld_rd        (ld_rd),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_req_addr (mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data (mem_rsp_data),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_data      (wb_data),
      .wb_rd        (wb_rd),
      .busy         (busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0;
   endfunction

   function automatic logic [31:0] req_at(input int i);
      if (req_log.size() > i) return req_log[i];
      return 32'hBAD0BAD0;
   endfunction

   // Memory responder: sees the request handshake just before the edge, answers one cycle later.
   initial begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
      pending       = 1'b0;
      pend_addr     = 32'h0;
      forever begin
         @(negedge clock);
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = 32'h0;
         if (inj) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hDEADBEEF;
            inj           = 1'b0;
         end else if (pending) begin
            if (auto_rsp) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = mem_rd(pend_addr);
            end
            pending = 1'b0;
         end
         if (mem_req_valid && mem_req_ready && !reset) begin
            pending   = 1'b1;
            pend_addr = mem_req_addr;
            req_log.push_back(mem_req_addr);
         end
      end
   end

   // Issue one load, wait for its writeback, accept it; lat counts negedges after accept.
   task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                           input logic [4:0] rd, output logic [31:0] d,
                           output logic [4:0] r, output int lat);
      int n;
      n = 0;
      while (!ld_ready && n < 20) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("ld_ready_wait", {31'b0, ld_ready}, 32'd1);
      ld_valid  = 1'b1;
      ld_addr   = a;
      ld_size   = sz;
      ld_signed = sg;
      ld_rd     = rd;
      @(posedge clock);
      #1;
      ld_valid = 1'b0;
      lat = 0;
      d   = 32'h0;
      r   = 5'h0;
      while (lat < 40) begin
         @(negedge clock);
         lat++;
         if (wb_valid) break;
      end
      chk("wb_valid_wait", {31'b0, wb_valid}, 32'd1);
      d = wb_data;
      r = wb_rd;
      wb_ready = 1'b1;
      @(posedge clock);
      #1;
      wb_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic [4:0]  r;
      int          lat;
      int          n;

      reset         = 1'b1;
      ld_valid      = 1'b0;
      ld_addr       = 32'h0;
      ld_size       = 2'b00;
      ld_signed     = 1'b0;
      ld_rd         = 5'h0;
      mem_req_ready = 1'b1;
      wb_ready      = 1'b0;
      auto_rsp      = 1'b1;
      inj           = 1'b0;

      vt[0] = '{32'h00000100, 2'd2, 1'b1, 5'd1,  32'h8899AABB, 1, 32'h00000100, 32'h0,        32'h8899AABB, 32'h0,        3};
      vt[1] = '{32'h00000103, 2'd0, 1'b1, 5'd2,  32'hFFFFFF80, 1, 32'h00000100, 32'h0,        32'h80112233, 32'h0,        3};
      vt[2] = '{32'h00000103, 2'd0, 1'b0, 5'd3,  32'h00000080, 1, 32'h00000100, 32'h0,        32'h80112233, 32'h0,        3};
      vt[3] = '{32'h00000102, 2'd1, 1'b1, 5'd4,  32'hFFFF8011, 1, 32'h00000100, 32'h0,        32'h80112233, 32'h0,        3};
      vt[4] = '{32'h00000101, 2'd0, 1'b0, 5'd5,  32'h00000022, 1, 32'h00000100, 32'h0,        32'h80112233, 32'h0,        3};
      vt[5] = '{32'h00000103, 2'd1, 1'b1, 5'd6,  32'hFFFFF1AA, 2, 32'h00000100, 32'h00000104, 32'hAA000000, 32'h000000F1, 5};
      vt[6] = '{32'h00000103, 2'd1, 1'b0, 5'd7,  32'h0000F1AA, 2, 32'h00000100, 32'h00000104, 32'hAA000000, 32'h000000F1, 5};
      vt[7] = '{32'hFFFFFFFE, 2'd2, 1'b0, 5'd8,  32'h56781234, 2, 32'hFFFFFFFC, 32'h00000000, 32'h1234ABCD, 32'h9ABC5678, 5};
      vt[8] = '{32'h00000100, 2'd3, 1'b1, 5'd9,  32'h81020304, 1, 32'h00000100, 32'h0,        32'h81020304, 32'h0,        3};
      vt[9] = '{32'h00000101, 2'd2, 1'b0, 5'd10, 32'h55443322, 2, 32'h00000100, 32'h00000104, 32'h44332211, 32'h88776655, 5};

      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
      chk("rst_wb_valid",      {31'b0, wb_valid},      32'd0);
      chk("rst_busy",          {31'b0, busy},          32'd0);
      chk("rst_wb_data",       wb_data,                32'h0);
      chk("rst_wb_rd",         {27'b0, wb_rd},         32'h0);
      chk("rst_mem_req_addr",  mem_req_addr,           32'h0);
      @(posedge clock);
      #1;
      chk("rst_ld_ready",      {31'b0, ld_ready},      32'd1);

      // Directed table: aligned, sub-word, split and wrap-around loads.
      for (int i = 0; i < 10; i++) begin
         mem[vt[i].r0] = vt[i].w0;
         if (vt[i].nreq == 2) mem[vt[i].r1] = vt[i].w1;
         req_log.delete();
         run_load(vt[i].a, vt[i].sz, vt[i].sg, vt[i].rd, d, r, lat);
         chk($sformatf("v%0d_data", i), d, vt[i].exp);
         chk($sformatf("v%0d_rd", i), {27'b0, r}, {27'b0, vt[i].rd});
         chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
         chk($sformatf("v%0d_nreq", i), req_log.size(), vt[i].nreq);
         chk($sformatf("v%0d_req0", i), req_at(0), vt[i].r0);
         if (vt[i].nreq == 2) chk($sformatf("v%0d_req1", i), req_at(1), vt[i].r1);
      end

      // Backpressure on both the memory request and the writeback.
      mem[32'h100] = 32'hCAFEF00D;
      req_log.delete();
      mem_req_ready = 1'b0;
      ld_valid  = 1'b1;
      ld_addr   = 32'h100;
      ld_size   = 2'd2;
      ld_signed = 1'b0;
      ld_rd     = 5'd17;
      @(posedge clock);
      #1;
      ld_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         chk("bp_req_valid", {31'b0, mem_req_valid}, 32'd1);
         chk("bp_req_addr",  mem_req_addr,           32'h100);
         chk("bp_ld_ready",  {31'b0, ld_ready},      32'd0);
         @(posedge clock);
         #1;
      end
      mem_req_ready = 1'b1;
      n = 0;
      while (!wb_valid && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("bp_wb_valid_wait", {31'b0, wb_valid}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         chk("bp_wb_valid", {31'b0, wb_valid}, 32'd1);
         chk("bp_wb_data",  wb_data,           32'hCAFEF00D);
         chk("bp_wb_rd",    {27'b0, wb_rd},    32'd17);
         chk("bp_ld_ready", {31'b0, ld_ready}, 32'd0);
         @(negedge clock);
      end
      wb_ready = 1'b1;
      @(posedge clock);
      #1;
      wb_ready = 1'b0;
      chk("bp_wb_drop",  {31'b0, wb_valid}, 32'd0);
      chk("bp_ready_up", {31'b0, ld_ready}, 32'd1);
      chk("bp_busy",     {31'b0, busy},     32'd0);
      chk("bp_nreq",     req_log.size(),    32'd1);

      // Reset while waiting for the first response, then a stale response.
      auto_rsp = 1'b0;
      mem[32'h100] = 32'h11111111;
      ld_valid  = 1'b1;
      ld_addr   = 32'h100;
      ld_size   = 2'd2;
      ld_signed = 1'b0;
      ld_rd     = 5'd3;
      @(posedge clock);
      #1;
      ld_valid = 1'b0;
      @(posedge clock);
      #1;
      chk("rs_busy_wait0", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      inj   = 1'b1;
      chk("rs_busy",      {31'b0, busy},          32'd0);
      chk("rs_wb_valid",  {31'b0, wb_valid},      32'd0);
      chk("rs_req_valid", {31'b0, mem_req_valid}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("rs_no_wb", {31'b0, wb_valid}, 32'd0);
      end
      auto_rsp = 1'b1;
      mem[32'h200] = 32'h13572468;
      @(posedge clock);
      #1;
      req_log.delete();
      run_load(32'h200, 2'd2, 1'b1, 5'd21, d, r, lat);
      chk("rs_next_data", d,          32'h13572468);
      chk("rs_next_rd",   {27'b0, r}, 32'd21);
      chk("rs_next_req",  req_at(0),  32'h200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
